// File: rtl/usb_reg_master.sv
// usb_reg_master: turns a byte-stream command channel from the USB front end
// into register-bus transactions and returns read bytes on a valid/ready channel.
// Frame: CTRL (bit0 read, bit1 hold), ADDR, LEN (0 = 256), then write payload.
// Optional feature: define USB_REG_TIMEOUT_EN to abort frames that stall
// mid-header or mid-payload for pTIMEOUT cycles (pulses timeout_err).
module usb_reg_master #(
    parameter int pBYTECNT_SIZE = 7,
    parameter int pREAD_CYCLES  = 2,
    parameter int pTIMEOUT      = 1024
) (
    input  logic                     clk_usb,
    input  logic                     reset_n,
    input  logic [7:0]               cmd_data,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    output logic [7:0]               reg_address,
    output logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
    output logic [7:0]               reg_datai,
    input  logic [7:0]               reg_datao,
    output logic                     reg_read,
    output logic                     reg_write,
    output logic [7:0]               rsp_data,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     busy,
    output logic                     timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_WDATA,
        S_RD_STROBE,
        S_RD_GAP
    } state_t;

    if (pREAD_CYCLES < 1 || pREAD_CYCLES > 15 || pTIMEOUT < 1 || pBYTECNT_SIZE < 1) begin : g_param_check
        $error("usb_reg_master: parameter out of range");
    end

    state_t                   state_q;
    logic [8:0]               idx_q;
    logic [8:0]               len_q;
    logic                     hold_q;
    logic                     read_q;
    logic [3:0]               rdcnt_q;
    logic                     cmd_ready_q;
    logic [7:0]               reg_address_q;
    logic [pBYTECNT_SIZE-1:0] reg_bytecnt_q;
    logic [7:0]               reg_datai_q;
    logic                     reg_read_q;
    logic                     reg_write_q;
    logic [7:0]               rsp_data_q;
    logic                     rsp_valid_q;
    logic                     busy_q;

    logic                     accept;
    logic                     slot_free;
    logic [8:0]               idx_inc;
    logic [pBYTECNT_SIZE-1:0] idx_bc;
    logic                     abort;

    assign accept    = cmd_valid && cmd_ready_q;
    // The response slot can take a new byte if it is empty or being drained this edge.
    assign slot_free = !rsp_valid_q || rsp_ready;
    assign idx_inc   = idx_q + 9'd1;
    assign idx_bc    = hold_q ? '0 : pBYTECNT_SIZE'(idx_q);

`ifdef USB_REG_TIMEOUT_EN
    localparam int TW = $clog2(pTIMEOUT + 1);

    logic [TW-1:0] to_q;
    logic          in_hdr;
    logic          timeout_err_q;

    assign in_hdr = (state_q == S_ADDR) || (state_q == S_LEN) || (state_q == S_WDATA);
    assign abort  = in_hdr && !cmd_valid && (to_q == TW'(pTIMEOUT - 1));

    // Counts consecutive starved cycles while a frame is waiting for command bytes.
    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            to_q          <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= abort;
            if (in_hdr && !cmd_valid && !abort) begin
                to_q <= to_q + TW'(1);
            end else begin
                to_q <= '0;
            end
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign abort       = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Frame parser and bus sequencer; every output is a register updated here.
    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            len_q         <= '0;
            hold_q        <= 1'b0;
            read_q        <= 1'b0;
            rdcnt_q       <= '0;
            cmd_ready_q   <= 1'b0;
            reg_address_q <= '0;
            reg_bytecnt_q <= '0;
            reg_datai_q   <= '0;
            reg_read_q    <= 1'b0;
            reg_write_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            reg_write_q <= 1'b0;
            if (rsp_valid_q && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    if (accept) begin
                        read_q  <= cmd_data[0];
                        hold_q  <= cmd_data[1];
                        busy_q  <= 1'b1;
                        state_q <= S_ADDR;
                    end
                end

                S_ADDR: begin
                    if (accept) begin
                        reg_address_q <= cmd_data;
                        state_q       <= S_LEN;
                    end
                end

                S_LEN: begin
                    if (accept) begin
                        len_q <= {(cmd_data == 8'd0), cmd_data};
                        idx_q <= '0;
                        if (read_q) begin
                            cmd_ready_q   <= 1'b0;
                            reg_bytecnt_q <= '0;
                            if (slot_free) begin
                                reg_read_q <= 1'b1;
                                rdcnt_q    <= '0;
                                state_q    <= S_RD_STROBE;
                            end else begin
                                state_q <= S_RD_GAP;
                            end
                        end else begin
                            state_q <= S_WDATA;
                        end
                    end
                end

                S_WDATA: begin
                    if (accept) begin
                        reg_write_q   <= 1'b1;
                        reg_datai_q   <= cmd_data;
                        reg_bytecnt_q <= idx_bc;
                        idx_q         <= idx_inc;
                        if (idx_inc == len_q) begin
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end
                end

                S_RD_STROBE: begin
                    if (rdcnt_q == 4'(pREAD_CYCLES - 1)) begin
                        rsp_data_q  <= reg_datao;
                        rsp_valid_q <= 1'b1;
                        reg_read_q  <= 1'b0;
                        idx_q       <= idx_inc;
                        state_q     <= S_RD_GAP;
                    end else begin
                        rdcnt_q <= rdcnt_q + 4'd1;
                    end
                end

                S_RD_GAP: begin
                    if (slot_free) begin
                        if (idx_q == len_q) begin
                            busy_q      <= 1'b0;
                            cmd_ready_q <= 1'b1;
                            state_q     <= S_IDLE;
                        end else begin
                            reg_read_q    <= 1'b1;
                            reg_bytecnt_q <= idx_bc;
                            rdcnt_q       <= '0;
                            state_q       <= S_RD_STROBE;
                        end
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            if (abort) begin
                state_q     <= S_IDLE;
                busy_q      <= 1'b0;
                cmd_ready_q <= 1'b1;
                reg_write_q <= 1'b0;
            end
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign reg_address = reg_address_q;
    assign reg_bytecnt = reg_bytecnt_q;
    assign reg_datai   = reg_datai_q;
    assign reg_read    = reg_read_q;
    assign reg_write   = reg_write_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_valid   = rsp_valid_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_usb_reg_master.sv
// tb_usb_reg_master: drives command frames into usb_reg_master, models a
// combinational register responder and compares observed bus/response events
// against expectations computed from the frame contents.
module tb_usb_reg_master;

    localparam int BC = 7;
    localparam int RC = 2;
    localparam int TO = 16;

    logic          clk_usb   = 1'b0;
    logic          reset_n   = 1'b0;
    logic [7:0]    cmd_data  = 8'h00;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [7:0]    reg_address;
    logic [BC-1:0] reg_bytecnt;
    logic [7:0]    reg_datai;
    logic [7:0]    reg_datao;
    logic          reg_read;
    logic          reg_write;
    logic [7:0]    rsp_data;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic          busy;
    logic          timeout_err;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit rsp_random = 1'b0;

    typedef struct {
        logic [7:0] addr;
        int         bc;
        logic [7:0] data;
        int         cyc;
        logic       busy;
    } ev_t;

    ev_t        wr_obs[$];
    ev_t        rd_obs[$];
    ev_t        rsp_obs[$];
    ev_t        to_obs[$];
    int         rd_len[$];
    logic [7:0] payload[$];
    int         rd_unstable = 0;
    int         hi_len = 0;
    logic       prev_read = 1'b0;
    logic [7:0] rd_a;
    logic [BC-1:0] rd_b;

    usb_reg_master #(
        .pBYTECNT_SIZE(BC),
        .pREAD_CYCLES (RC),
        .pTIMEOUT     (TO)
    ) dut (
        .clk_usb    (clk_usb),
        .reset_n    (reset_n),
        .cmd_data   (cmd_data),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .reg_address(reg_address),
        .reg_bytecnt(reg_bytecnt),
        .reg_datai  (reg_datai),
        .reg_datao  (reg_datao),
        .reg_read   (reg_read),
        .reg_write  (reg_write),
        .rsp_data   (rsp_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk_usb = ~clk_usb;

    // Responder: address 0x10 returns 0xA0 + byte index, others are offset from it.
    function automatic logic [7:0] resp_byte(input logic [7:0] a, input int bc);
        return 8'(8'hA0 + 8'(bc) + (a - 8'h10));
    endfunction

    assign reg_datao = resp_byte(reg_address, int'(reg_bytecnt));

    always @(posedge clk_usb) cyc = cyc + 1;

    initial forever begin
        @(posedge clk_usb);
        #1;
        if (rsp_random) rsp_ready = ($urandom_range(0, 3) != 0);
    end

    // Records bus events between clock edges for the scenario tasks to inspect.
    always @(negedge clk_usb) begin
        ev_t e;
        if (reset_n) begin
            e.addr = reg_address;
            e.bc   = int'(reg_bytecnt);
            e.data = reg_datai;
            e.cyc  = cyc;
            e.busy = busy;
            if (reg_write) wr_obs.push_back(e);
            if (reg_read && !prev_read) begin
                rd_obs.push_back(e);
                hi_len = 1;
                rd_a = reg_address;
                rd_b = reg_bytecnt;
            end else if (reg_read) begin
                hi_len++;
                if (reg_address !== rd_a || reg_bytecnt !== rd_b) rd_unstable++;
            end else if (prev_read) begin
                rd_len.push_back(hi_len);
            end
            if (rsp_valid && rsp_ready) begin
                e.data = rsp_data;
                rsp_obs.push_back(e);
            end
            if (timeout_err) to_obs.push_back(e);
            prev_read = reg_read;
        end else begin
            prev_read = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic clear_obs();
        wr_obs.delete();
        rd_obs.delete();
        rsp_obs.delete();
        to_obs.delete();
        rd_len.delete();
        rd_unstable = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, output int acc);
        cmd_data  = b;
        cmd_valid = 1'b1;
        acc       = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk_usb);
            if (cmd_ready === 1'b1) begin
                acc = cyc + 1;
                break;
            end
        end
        @(posedge clk_usb);
        #1;
        if (acc < 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL send_byte: byte %02h not accepted within 200 cycles", b);
        end
    endtask

    task automatic send_frame(input logic [7:0] ctrl, input logic [7:0] addr,
                              input logic [7:0] len, input int max_gap, output int len_acc);
        int acc;
        send_byte(ctrl, acc);
        send_byte(addr, acc);
        send_byte(len, len_acc);
        if (!ctrl[0]) begin
            for (int i = 0; i < payload.size(); i++) begin
                if (max_gap > 0) begin
                    int g = $urandom_range(0, max_gap);
                    if (g > 0) begin
                        cmd_valid = 1'b0;
                        repeat (g) @(posedge clk_usb);
                        #1;
                    end
                end
                send_byte(payload[i], acc);
            end
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        cmd_valid = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk_usb);
            if (!busy && !rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk_usb);
        #1;
        if (!ok) begin
            tests++;
            fails++;
            $display("[TB] FAIL wait_done: busy=%0b rsp_valid=%0b after 3000 cycles", busy, rsp_valid);
        end
    endtask

    task automatic applyStimulus();
        // Waits one idle clock cycle for scenarios that need a settling gap
        @(posedge clk_usb);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk_usb);
        tests++;
        if (cmd_ready !== 1'b0 || busy !== 1'b0 || timeout_err !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_ctrl: cmd_ready=%b busy=%b timeout_err=%b, expected 0/0/0", cmd_ready, busy, timeout_err);
        end
        tests++;
        if (reg_read !== 1'b0 || reg_write !== 1'b0 || rsp_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_strobes: read=%b write=%b rsp_valid=%b, expected 0/0/0", reg_read, reg_write, rsp_valid);
        end
        tests++;
        if (reg_address !== 8'h00 || reg_bytecnt !== '0 || reg_datai !== 8'h00 || rsp_data !== 8'h00) begin
            fails++;
            $display("[TB] FAIL reset_data: addr=%h bc=%h datai=%h rsp=%h, expected all 0", reg_address, reg_bytecnt, reg_datai, rsp_data);
        end
        reset_n = 1'b1;
        repeat (2) @(posedge clk_usb);
        #1;
        tests++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL idle_after_reset: cmd_ready=%b busy=%b, expected 1/0", cmd_ready, busy);
        end
    endtask

    task automatic test_write();
        logic [7:0] exp_d[3];
        int la;
        exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
        clear_obs();
        payload.delete();
        for (int i = 0; i < 3; i++) payload.push_back(exp_d[i]);
        send_frame(8'h00, 8'h25, 8'h03, 0, la);
        wait_done();
        tests++;
        if (wr_obs.size() != 3) begin
            fails++;
            $display("[TB] FAIL write_count: got %0d pulses, expected 3", wr_obs.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests++;
                if (wr_obs[i].addr !== 8'h25 || wr_obs[i].bc != i || wr_obs[i].data !== exp_d[i]) begin
                    fails++;
                    $display("[TB] FAIL write_beat%0d: addr=%h bc=%0d data=%h, expected 25/%0d/%h",
                             i, wr_obs[i].addr, wr_obs[i].bc, wr_obs[i].data, i, exp_d[i]);
                end
            end
            tests++;
            if (wr_obs[1].cyc - wr_obs[0].cyc != 1 || wr_obs[2].cyc - wr_obs[1].cyc != 1) begin
                fails++;
                $display("[TB] FAIL write_consecutive: cycles %0d %0d %0d, expected consecutive",
                         wr_obs[0].cyc, wr_obs[1].cyc, wr_obs[2].cyc);
            end
            tests++;
            if (wr_obs[0].busy !== 1'b1 || wr_obs[2].busy !== 1'b0) begin
                fails++;
                $display("[TB] FAIL write_busy: busy at first/last pulse=%b/%b, expected 1/0", wr_obs[0].busy, wr_obs[2].busy);
            end
        end
    endtask

    task automatic test_read();
        int la;
        clear_obs();
        rsp_ready = 1'b1;
        send_frame(8'h01, 8'h10, 8'h02, 0, la);
        wait_done();
        tests++;
        if (rd_obs.size() != 2 || rsp_obs.size() != 2 || rd_len.size() != 2) begin
            fails++;
            $display("[TB] FAIL read_count: rises=%0d rsp=%0d, expected 2/2", rd_obs.size(), rsp_obs.size());
        end else begin
            tests++;
            if (rd_obs[0].cyc != la) begin
                fails++;
                $display("[TB] FAIL read_latency: first rise cycle %0d, expected %0d", rd_obs[0].cyc, la);
            end
            tests++;
            if (rd_obs[1].cyc - rd_obs[0].cyc != RC + 1 || rd_len[0] != RC || rd_len[1] != RC) begin
                fails++;
                $display("[TB] FAIL read_pattern: period=%0d high=%0d/%0d, expected %0d/%0d",
                         rd_obs[1].cyc - rd_obs[0].cyc, rd_len[0], rd_len[1], RC + 1, RC);
            end
            tests++;
            if (rsp_obs[0].data !== 8'hA0 || rsp_obs[1].data !== 8'hA1) begin
                fails++;
                $display("[TB] FAIL read_data: got %h %h, expected A0 A1", rsp_obs[0].data, rsp_obs[1].data);
            end
            tests++;
            if (rd_obs[0].bc != 0 || rd_obs[1].bc != 1 || rd_obs[0].addr !== 8'h10 || rd_unstable != 0) begin
                fails++;
                $display("[TB] FAIL read_addr: bc=%0d/%0d addr=%h unstable=%0d, expected 0/1/10/0",
                         rd_obs[0].bc, rd_obs[1].bc, rd_obs[0].addr, rd_unstable);
            end
        end
    endtask

    task automatic test_read_stall();
        int la;
        bit seen = 1'b0;
        clear_obs();
        rsp_ready = 1'b0;
        send_frame(8'h01, 8'h10, 8'h02, 0, la);
        for (int n = 0; n < 100; n++) begin
            @(negedge clk_usb);
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("[TB] FAIL stall_first_rsp: rsp_valid=0, expected 1 within 100 cycles");
        end
        @(posedge clk_usb);
        #1;
        repeat (10) @(posedge clk_usb);
        #1;
        rsp_ready = 1'b1;
        wait_done();
        tests++;
        if (rsp_obs.size() != 2 || rd_obs.size() != 2) begin
            fails++;
            $display("[TB] FAIL stall_count: rsp=%0d rises=%0d, expected 2/2", rsp_obs.size(), rd_obs.size());
        end else begin
            tests++;
            if (rsp_obs[0].data !== 8'hA0 || rsp_obs[1].data !== 8'hA1) begin
                fails++;
                $display("[TB] FAIL stall_data: got %h %h, expected A0 A1", rsp_obs[0].data, rsp_obs[1].data);
            end
            tests++;
            if (rd_obs[1].cyc <= rsp_obs[0].cyc || rd_obs[1].cyc - rd_obs[0].cyc <= 10) begin
                fails++;
                $display("[TB] FAIL stall_order: second rise %0d, first accept %0d, expected rise after accept",
                         rd_obs[1].cyc, rsp_obs[0].cyc);
            end
        end
    endtask

    task automatic test_len256();
        int la;
        int bad = 0;
        clear_obs();
        payload.delete();
        for (int i = 0; i < 256; i++) payload.push_back(8'($urandom));
        send_frame(8'h00, 8'h5A, 8'h00, 0, la);
        wait_done();
        tests++;
        if (wr_obs.size() != 256) begin
            fails++;
            $display("[TB] FAIL len256_count: got %0d pulses, expected 256", wr_obs.size());
        end else begin
            for (int i = 0; i < 256; i++) begin
                tests++;
                if (wr_obs[i].addr !== 8'h5A || wr_obs[i].bc != (i % (1 << BC)) || wr_obs[i].data !== payload[i]) begin
                    fails++;
                    if (bad++ < 4)
                        $display("[TB] FAIL len256_beat%0d: addr=%h bc=%0d data=%h, expected 5a/%0d/%h",
                                 i, wr_obs[i].addr, wr_obs[i].bc, wr_obs[i].data, i % (1 << BC), payload[i]);
                end
            end
            tests++;
            if (wr_obs[255].cyc - wr_obs[0].cyc != 255) begin
                fails++;
                $display("[TB] FAIL len256_rate: span %0d cycles, expected 255", wr_obs[255].cyc - wr_obs[0].cyc);
            end
        end
    endtask

    task automatic test_hold_read();
        int la;
        clear_obs();
        rsp_ready = 1'b1;
        send_frame(8'h03, 8'h44, 8'h04, 0, la);
        wait_done();
        tests++;
        if (rd_obs.size() != 4 || rsp_obs.size() != 4) begin
            fails++;
            $display("[TB] FAIL hold_count: rises=%0d rsp=%0d, expected 4/4", rd_obs.size(), rsp_obs.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (rd_obs[i].bc != 0 || rsp_obs[i].data !== resp_byte(8'h44, 0)) begin
                    fails++;
                    $display("[TB] FAIL hold_beat%0d: bc=%0d data=%h, expected 0/%h",
                             i, rd_obs[i].bc, rsp_obs[i].data, resp_byte(8'h44, 0));
                end
            end
        end
    endtask

    task automatic test_timeout();
        int acc;
        int la;
        clear_obs();
        send_byte(8'h00, acc);
        send_byte(8'h33, acc);
        cmd_valid = 1'b0;
        repeat (40) @(negedge clk_usb);
`ifdef USB_REG_TIMEOUT_EN
        tests++;
        if (to_obs.size() != 1) begin
            fails++;
            $display("[TB] FAIL timeout_pulse: got %0d pulse cycles, expected 1", to_obs.size());
        end else begin
            tests++;
            if (to_obs[0].cyc - acc != TO || to_obs[0].busy !== 1'b0) begin
                fails++;
                $display("[TB] FAIL timeout_when: after %0d cycles busy=%b, expected %0d/0",
                         to_obs[0].cyc - acc, to_obs[0].busy, TO);
            end
        end
        @(posedge clk_usb);
        #1;
        clear_obs();
        payload.delete();
        payload.push_back(8'h77);
        send_frame(8'h00, 8'h34, 8'h01, 0, la);
        wait_done();
        tests++;
        if (wr_obs.size() != 1 || wr_obs[0].addr !== 8'h34 || wr_obs[0].data !== 8'h77) begin
            fails++;
            $display("[TB] FAIL timeout_recover: %0d writes, expected one write 77 to 34", wr_obs.size());
        end
`else
        tests++;
        if (busy !== 1'b1 || to_obs.size() != 0) begin
            fails++;
            $display("[TB] FAIL no_timeout: busy=%b pulses=%0d, expected 1/0", busy, to_obs.size());
        end
        @(posedge clk_usb);
        #1;
        send_byte(8'h01, la);
        send_byte(8'h77, la);
        wait_done();
        tests++;
        if (wr_obs.size() != 1 || wr_obs[0].addr !== 8'h33 || wr_obs[0].data !== 8'h77) begin
            fails++;
            $display("[TB] FAIL stall_resume: %0d writes, expected one write 77 to 33", wr_obs.size());
        end
`endif
    endtask

    task automatic test_reset_mid();
        int acc;
        int la;
        clear_obs();
        send_byte(8'h00, acc);
        send_byte(8'h66, acc);
        send_byte(8'h08, acc);
        for (int i = 0; i < 4; i++) send_byte(8'(8'hC0 + i), acc);
        @(negedge clk_usb);
        #2;
        reset_n = 1'b0;
        #1;
        tests++;
        if (busy !== 1'b0 || cmd_ready !== 1'b0 || reg_write !== 1'b0 || rsp_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL async_reset_ctrl: busy=%b cmd_ready=%b write=%b rsp_valid=%b, expected 0",
                     busy, cmd_ready, reg_write, rsp_valid);
        end
        tests++;
        if (reg_address !== 8'h00 || reg_bytecnt !== '0 || reg_datai !== 8'h00) begin
            fails++;
            $display("[TB] FAIL async_reset_data: addr=%h bc=%h datai=%h, expected 0", reg_address, reg_bytecnt, reg_datai);
        end
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk_usb);
        reset_n = 1'b1;
        @(posedge clk_usb);
        #1;
        clear_obs();
        payload.delete();
        payload.push_back(8'hAA);
        payload.push_back(8'hBB);
        send_frame(8'h00, 8'h67, 8'h02, 0, la);
        wait_done();
        tests++;
        if (wr_obs.size() != 2 || wr_obs[0].bc != 0 || wr_obs[1].bc != 1 || wr_obs[1].data !== 8'hBB) begin
            fails++;
            $display("[TB] FAIL reset_fresh_frame: %0d writes, expected fresh burst bc 0,1", wr_obs.size());
        end
    endtask

    task automatic test_random();
        logic [7:0] ctrl;
        logic [7:0] addr;
        int         n;
        int         la;
        int         bc;
        rsp_random = 1'b1;
        for (int f = 0; f < 16; f++) begin
            ctrl = 8'($urandom);
            addr = 8'($urandom);
            n    = $urandom_range(1, 7);
            clear_obs();
            payload.delete();
            for (int i = 0; i < n; i++) payload.push_back(8'($urandom));
            send_frame(ctrl, addr, 8'(n), 2, la);
            wait_done();
            tests++;
            if (wr_obs.size() != (ctrl[0] ? 0 : n) || rd_obs.size() != (ctrl[0] ? n : 0) ||
                rsp_obs.size() != (ctrl[0] ? n : 0) || rd_unstable != 0) begin
                fails++;
                $display("[TB] FAIL rand%0d_count: ctrl=%h n=%0d writes=%0d reads=%0d rsp=%0d unstable=%0d",
                         f, ctrl, n, wr_obs.size(), rd_obs.size(), rsp_obs.size(), rd_unstable);
            end else begin
                for (int i = 0; i < n; i++) begin
                    bc = ctrl[1] ? 0 : (i % (1 << BC));
                    tests++;
                    if (ctrl[0]) begin
                        if (rd_obs[i].addr !== addr || rd_obs[i].bc != bc ||
                            rsp_obs[i].data !== resp_byte(addr, bc) || rd_len[i] != RC) begin
                            fails++;
                            $display("[TB] FAIL rand%0d_rd%0d: addr=%h bc=%0d data=%h high=%0d, expected %h/%0d/%h/%0d",
                                     f, i, rd_obs[i].addr, rd_obs[i].bc, rsp_obs[i].data, rd_len[i],
                                     addr, bc, resp_byte(addr, bc), RC);
                        end
                    end else begin
                        if (wr_obs[i].addr !== addr || wr_obs[i].bc != bc || wr_obs[i].data !== payload[i]) begin
                            fails++;
                            $display("[TB] FAIL rand%0d_wr%0d: addr=%h bc=%0d data=%h, expected %h/%0d/%h",
                                     f, i, wr_obs[i].addr, wr_obs[i].bc, wr_obs[i].data, addr, bc, payload[i]);
                        end
                    end
                end
            end
        end
        rsp_random = 1'b0;
        rsp_ready  = 1'b1;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_read_stall();
        test_len256();
        test_hold_read();
        test_timeout();
        test_reset_mid();
        test_random();
        applyStimulus();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/usb_reg_master.md
# usb_reg_master

Register-bus initiator on the `clk_usb` domain. It parses a byte-stream command channel coming from the USB front end into register transactions. It drives `reg_address`, `reg_bytecnt`, `reg_datai`, `reg_read` and `reg_write` toward the OpenADC register responders, and returns read bytes sampled from `reg_datao` on a valid/ready response channel. Each read byte gets a fresh rising edge of `reg_read`, so responder FIFO-pop logic sees exactly one edge per byte.

## Interface
- `pBYTECNT_SIZE`, 7: width of `reg_bytecnt`.
- `pREAD_CYCLES`, 2: cycles `reg_read` is held high per read byte (range 1..15).
- `pTIMEOUT`, 1024: idle-cycle limit mid-frame; used only with `USB_REG_TIMEOUT_EN`.
- `clk_usb` in 1: sole clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmd_data` in 8: command stream byte.
- `cmd_valid` in 1: `cmd_data` valid.
- `cmd_ready` out 1: byte accepted when `cmd_valid & cmd_ready`.
- `reg_address` out 8: register address.
- `reg_bytecnt` out `pBYTECNT_SIZE`: byte index within the burst.
- `reg_datai` out 8: write data.
- `reg_datao` in 8: read data from the responders (combinational on their side).
- `reg_read` out 1: read strobe.
- `reg_write` out 1: write strobe, one cycle per byte.
- `rsp_data` out 8: read byte returned upstream.
- `rsp_valid` out 1: `rsp_data` valid.
- `rsp_ready` in 1: upstream accepts `rsp_data`.
- `busy` out 1: high in any state other than IDLE.
- `timeout_err` out 1: one-cycle pulse on a frame abort (tied 0 without the macro).

## Operation
- Frame format is three header bytes, then write payload if the frame is a write:
  - CTRL: bit0 = 1 read / 0 write; bit1 = hold (`reg_bytecnt` fixed at 0); bits 7:2 are ignored.
  - ADDR: register address.
  - LEN: byte count; 0 means 256.
- The burst counter is 9 bits wide.
- `reg_bytecnt` is the burst index truncated to `pBYTECNT_SIZE` bits, so it wraps (e.g. 127 -> 0). In hold mode it is always 0.
- States: IDLE, ADDR, LEN, WDATA, RD_STROBE, RD_GAP.
- IDLE -> ADDR on CTRL accept.
- ADDR -> LEN on ADDR accept. `reg_address` is updated at this point and held until the next frame's ADDR.
- LEN -> WDATA (write) or RD_STROBE (read) on LEN accept.
- WDATA: each accepted byte produces a `reg_write` pulse. After the last byte the FSM returns to IDLE.
- RD_STROBE: `reg_read` = 1 for `pREAD_CYCLES` cycles.
  - `reg_datao` is registered into `rsp_data` on the last high cycle.
  - `rsp_valid` = 1 from the next cycle.
  - The FSM then enters RD_GAP.
- RD_GAP: `reg_read` = 0 for at least one cycle. The FSM stays here while `rsp_valid & ~rsp_ready`. It then goes to RD_STROBE with the index incremented, or to IDLE after the last byte.
- `cmd_ready` = 1 in IDLE, ADDR, LEN and WDATA; 0 in the read states.
- The response slot is a single register. It is cleared on `rsp_valid & rsp_ready` and is independent of later frames.
  - A new read frame stalls in RD_GAP-equivalent fashion: it does not enter RD_STROBE while the slot is still full.
  - A write frame proceeds regardless of a pending response.
- Reset values: `reg_read`, `reg_write`, `reg_address`, `reg_bytecnt`, `reg_datai`, `rsp_data`, `rsp_valid`, `busy`, `timeout_err` = 0; `cmd_ready` = 0 while `reset_n` = 0; state = IDLE.
- Asserting `reset_n` low mid-frame aborts the frame immediately. The partial burst is not resumed.

## Timing
- All outputs are registered.
- Header: with continuous `cmd_valid`, CTRL/ADDR/LEN are accepted on consecutive edges.
- Write: a byte accepted at edge k gives `reg_write` = 1 during cycle k+1, with `reg_datai` and `reg_bytecnt` valid in the same cycle. Peak rate is 1 byte/clk.
- `reg_address` is stable for the whole payload.
- The first write byte may arrive on the cycle after LEN.
- Read: first `reg_read` rise is 1 cycle after the LEN accept. Per byte the period is `pREAD_CYCLES` + 1 cycles when `rsp_ready` = 1. `reg_address` and `reg_bytecnt` are stable while `reg_read` = 1.
- `rsp_valid` rises the cycle after the last `reg_read`-high cycle of that byte.

## Configuration
- `USB_REG_TIMEOUT_EN` defined:
  - A counter runs in ADDR, LEN and WDATA while `cmd_valid` = 0, and clears on any accept.
  - On reaching `pTIMEOUT` the FSM returns to IDLE and `timeout_err` pulses for one cycle.
  - Read states are exempt from the timeout.
- `USB_REG_TIMEOUT_EN` undefined: the FSM waits indefinitely, `timeout_err` = 0 and no counter is instantiated.

## Test plan
- Write frame {00,25,03,11,22,33}, continuous valid -> three consecutive `reg_write` pulses; `reg_datai` 11/22/33, `reg_bytecnt` 0/1/2, `reg_address` 25; `busy` low after the last byte.
- Read frame {01,10,02}, responder returns 0xA0+`reg_bytecnt`, `rsp_ready`=1 -> `reg_read` pattern 1,1,0,1,1; `rsp_data` A0 then A1; `rsp_valid` asserted once per byte.
- Same read with `rsp_ready`=0 for 10 cycles after the first byte -> `reg_read` stays low until A0 is accepted; then A1 follows; no byte lost or duplicated.
- Write frame with LEN=00 and `pBYTECNT_SIZE`=7 -> 256 `reg_write` pulses; `reg_bytecnt` wraps 127 -> 0.
- Hold read {03,ADDR,04} -> four distinct `reg_read` rising edges, `reg_bytecnt` = 0 throughout, four response bytes.
- Timeout scenario (`USB_REG_TIMEOUT_EN`, `pTIMEOUT`=16): stall for 16 cycles after ADDR -> one-cycle `timeout_err`, FSM back in IDLE, next frame completes correctly.
- Reset scenario: drive `reset_n`=0 mid-payload -> all outputs return to reset values asynchronously.
